// File: rtl/rmii_byte_assembler.sv
// rmii_byte_assembler: packs the 2-bit RMII payload stream into bytes,
// holds each byte one byte-time so the final byte of a frame can be tagged
// with axiol, and issues a per-frame verdict (alignment, length, FCS).
// Optional feature macro: RMII_FCS_CHECK_EN -- when defined, a CRC-32
// residue check is included and gates frame_ok.
module rmii_byte_assembler #(
  parameter int unsigned MIN_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [7:0]  axiod,
  output logic        axiol,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] byte_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic [11:0] MIN_BYTES_W = 12'(MIN_BYTES);
  localparam logic [10:0] CNT_MAX     = 11'h7FF;

`ifdef RMII_FCS_CHECK_EN
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Reflected CRC-32 advanced by one dibit, bit 0 of the dibit first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc_in,
                                              input logic [1:0]  dibit);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 2; i++) begin
      if ((c[0] ^ dibit[i]) == 1'b1) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [31:0] crc_q, crc_d;
`endif

  state_t      state_q, state_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [5:0]  shift_q, shift_d;       // dibits 0..2 of the byte in progress
  logic [7:0]  hold_q, hold_d;         // last completed byte, not yet emitted
  logic        hold_valid_q, hold_valid_d;
  logic [10:0] cnt_q, cnt_d;           // live byte counter for this frame
  logic        axiov_q, axiov_d;
  logic [7:0]  axiod_q, axiod_d;
  logic        axiol_q, axiol_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic        frame_pass_s;

  // Frame verdict as it would be judged if the frame ended this edge.
  always_comb begin
    frame_pass_s = (dcnt_q == 2'd0) && ({1'b0, cnt_q} >= MIN_BYTES_W);
`ifdef RMII_FCS_CHECK_EN
    frame_pass_s = frame_pass_s && (crc_q == CRC_RESIDUE);
`endif
  end

  // Next-state: dibit packing, byte hold/emit, end-of-frame handling.
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    axiov_d      = 1'b0;
    axiod_d      = axiod_q;
    axiol_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    byte_count_d = byte_count_q;
`ifdef RMII_FCS_CHECK_EN
    crc_d        = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (axiiv) begin
          // First dibit of a new frame becomes dibit 0.
          state_d = ST_RECV;
          dcnt_d  = 2'd1;
          shift_d = {axiid, 4'b0000};
`ifdef RMII_FCS_CHECK_EN
          crc_d   = crc32_dibit(CRC_INIT, axiid);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (axiiv) begin
          dcnt_d  = dcnt_q + 2'd1;
          shift_d = {axiid, shift_q[5:2]};
`ifdef RMII_FCS_CHECK_EN
          crc_d   = crc32_dibit(crc_q, axiid);
`endif
          if (dcnt_q == 2'd3) begin
            // Byte complete: release the previous one, hold this one.
            if (hold_valid_q) begin
              axiov_d = 1'b1;
              axiod_d = hold_q;
              axiol_d = 1'b0;
            end else begin
              axiov_d = 1'b0;
            end
            hold_d       = {axiid, shift_q};
            hold_valid_d = 1'b1;
            cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 11'd1);
          end else begin
            hold_valid_d = hold_valid_q;
          end
        end else begin
          // End of frame: flush the held byte as the last one, give verdict.
          if (hold_valid_q) begin
            axiov_d = 1'b1;
            axiod_d = hold_q;
            axiol_d = 1'b1;
          end else begin
            axiov_d = 1'b0;
          end
          frame_done_d = 1'b1;
          frame_ok_d   = frame_pass_s;
          byte_count_d = cnt_q;
          state_d      = ST_IDLE;
          dcnt_d       = 2'd0;
          hold_valid_d = 1'b0;
          cnt_d        = 11'd0;
`ifdef RMII_FCS_CHECK_EN
          crc_d        = CRC_INIT;
`endif
        end
      end
      default: begin
        state_d      = ST_IDLE;
        dcnt_d       = 2'd0;
        hold_valid_d = 1'b0;
        cnt_d        = 11'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dcnt_q       <= 2'd0;
      shift_q      <= 6'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      cnt_q        <= 11'd0;
      axiov_q      <= 1'b0;
      axiod_q      <= 8'd0;
      axiol_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      byte_count_q <= 11'd0;
`ifdef RMII_FCS_CHECK_EN
      crc_q        <= CRC_INIT;
`endif
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      axiol_q      <= axiol_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      byte_count_q <= byte_count_d;
`ifdef RMII_FCS_CHECK_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign axiol      = axiol_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rmii_byte_assembler.sv
// Testbench for rmii_byte_assembler: directed frames, a per-cycle expected
// event stream built from the frame contents, and literal frame results.
module tb_rmii_byte_assembler;

  localparam int MIN_BYTES = 4;
`ifdef RMII_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef logic [1:0] dq_t[$];
  typedef struct {
    int          cyc;
    bit          v;
    bit          l;
    logic [7:0]  d;
    bit          fd;
    bit          ok;
    logic [10:0] cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;
  logic        axiov;
  logic [7:0]  axiod;
  logic        axiol;
  logic        frame_done;
  logic        frame_ok;
  logic [10:0] byte_count;

  rmii_byte_assembler #(.MIN_BYTES(MIN_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .axiol(axiol),
    .frame_done(frame_done), .frame_ok(frame_ok), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  bit   last_ok = 1'b0;
  logic [10:0] last_cnt = 11'd0;
  int   obs_cnt[$];
  int   obs_ok[$];
  int   obs_bytes = 0;
  logic [7:0] first_byte = 8'h00;
  bit   got_first = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Standard byte-wise Ethernet CRC-32 (final value inverted).
  function automatic logic [31:0] model_crc(input bq_t b, input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h000000, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

`ifdef RMII_FCS_CHECK_EN
  // Frame carries a correct FCS: CRC of payload equals trailing 4 bytes (LSB first).
  function automatic bit fcs_good(input bq_t b);
    int n;
    n = b.size();
    if (n < 4) return 1'b0;
    return model_crc(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
  endfunction
`endif

  function automatic dq_t to_dibits(input bq_t b);
    dq_t q;
    logic [7:0] x;
    foreach (b[i]) begin
      x = b[i];
      for (int k = 0; k < 4; k++) q.push_back(x[2*k +: 2]);
    end
    return q;
  endfunction

  // Drive a frame of dibits and queue the outputs it must produce, by cycle.
  task automatic send_dibits(input dq_t dq, input int gap, input bit abort);
    int s;
    int n;
    bq_t byts;
    logic [7:0] cur;
    ev_t e;
    bit okv;
    s = cyc + 1;
    cur = 8'h00;
    foreach (dq[j]) begin
      axiiv = 1'b1;
      axiid = dq[j];
      cur = cur | (8'(dq[j]) << (2 * (j % 4)));
      if (j % 4 == 3) begin
        byts.push_back(cur);
        cur = 8'h00;
        if (byts.size() >= 2) begin
          e.cyc = s + j; e.v = 1'b1; e.l = 1'b0; e.d = byts[byts.size()-2];
          e.fd = 1'b0; e.ok = 1'b0; e.cnt = 11'd0;
          exp_q.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    if (abort) return;
    axiiv = 1'b0;
    axiid = 2'b00;
    n = byts.size();
    okv = (dq.size() % 4 == 0) && (n >= MIN_BYTES);
`ifdef RMII_FCS_CHECK_EN
    if (okv) okv = fcs_good(byts);
`endif
    e.cyc = s + dq.size();
    e.v   = (n > 0);
    e.l   = (n > 0);
    e.d   = (n > 0) ? byts[n-1] : 8'h00;
    e.fd  = 1'b1;
    e.ok  = okv;
    e.cnt = (n > 2047) ? 11'd2047 : 11'(n);
    exp_q.push_back(e);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Compare DUT outputs with the expected event stream every cycle.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      chk("rst_axiov", 32'(axiov), 32'd0);
      chk("rst_axiod", 32'(axiod), 32'd0);
      chk("rst_axiol", 32'(axiol), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_frame_ok", 32'(frame_ok), 32'd0);
      chk("rst_byte_count", 32'(byte_count), 32'd0);
      last_ok  = 1'b0;
      last_cnt = 11'd0;
    end else begin
      e.cyc = 0; e.v = 1'b0; e.l = 1'b0; e.d = 8'h00; e.fd = 1'b0; e.ok = 1'b0; e.cnt = 11'd0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_event_cycle", 32'(exp_q[0].cyc), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
      chk("axiov", 32'(axiov), 32'(e.v));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      if (e.v) begin
        chk("axiod", 32'(axiod), 32'(e.d));
        chk("axiol", 32'(axiol), 32'(e.l));
      end
      if (e.fd) begin
        last_ok  = e.ok;
        last_cnt = e.cnt;
      end
      chk("frame_ok", 32'(frame_ok), 32'(last_ok));
      chk("byte_count", 32'(byte_count), 32'(last_cnt));
      if (axiov) begin
        obs_bytes++;
        if (!got_first) begin
          first_byte = axiod;
          got_first  = 1'b1;
        end
      end
      if (frame_done) begin
        obs_cnt.push_back(int'(byte_count));
        obs_ok.push_back(int'(frame_ok));
      end
    end
  end

  // Watchdog: the run must end on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bq_t good;
    bq_t bad;
    bq_t zeros;
    bq_t payload;
    dq_t dq;
    int exp_cnts[9];
    int exp_oks[9];

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    payload = good;
    repeat (4) void'(payload.pop_back());
    chk("model_crc_123456789", model_crc(payload, 9), 32'hCBF4_3926);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte 0x39, too short to be good.
    dq = '{2'b01, 2'b10, 2'b11, 2'b00};
    send_dibits(dq, 3, 1'b0);
    // Zero-byte frame.
    dq = '{2'b11, 2'b01};
    send_dibits(dq, 3, 1'b0);
    // Good FCS frame.
    send_dibits(to_dibits(good), 3, 1'b0);
    // Corrupted FCS.
    bad = good;
    bad[12] = 8'hCA;
    send_dibits(to_dibits(bad), 3, 1'b0);
    // Misaligned: two extra dibits.
    dq = to_dibits(good);
    dq.push_back(2'b01);
    dq.push_back(2'b10);
    send_dibits(dq, 3, 1'b0);
    // Back-to-back with a one-cycle gap.
    send_dibits(to_dibits(good), 1, 1'b0);
    send_dibits(to_dibits(good), 3, 1'b0);
    // Reset after 6 bytes of a frame.
    dq = to_dibits(good);
    while (dq.size() > 24) void'(dq.pop_back());
    send_dibits(dq, 0, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    axiiv = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_dibits(to_dibits(good), 3, 1'b0);
    // Byte counter saturation: 2050 bytes.
    for (int i = 0; i < 2050; i++) zeros.push_back(8'h00);
    send_dibits(to_dibits(zeros), 3, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    chk("events_drained", 32'(exp_q.size()), 32'd0);
    exp_cnts = '{1, 0, 13, 13, 13, 13, 13, 13, 2047};
    exp_oks  = '{0, 0, 1, (FCS_EN ? 0 : 1), 0, 1, 1, 1, (FCS_EN ? 0 : 1)};
    chk("frame_count", 32'(obs_cnt.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < obs_cnt.size()) begin
        chk($sformatf("frame%0d_byte_count", i), 32'(obs_cnt[i]), 32'(exp_cnts[i]));
        chk($sformatf("frame%0d_frame_ok", i), 32'(obs_ok[i]), 32'(exp_oks[i]));
      end
    end
    chk("first_byte", 32'(first_byte), 32'h39);
    chk("total_bytes", 32'(obs_bytes), 32'd2134);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmii_byte_assembler.md
# rmii_byte_assembler

Packs the 2-bit RMII payload stream from the Ethernet receive preamble stripper into bytes, tags the final byte of each frame, and checks the Ethernet FCS. It sits directly downstream of the preamble stripper and feeds byte-wide frame consumers such as header parsers and the NAL/packet extractor. Each byte is held one byte-time so the last byte of a frame carries a `last` flag.

## Interface
Parameters:
- `MIN_BYTES`, default 4: minimum byte count, FCS included, for a frame to be judged good.

Ports:
- `clk`  in  1  system clock, 50 MHz RMII domain
- `rst_n`  in  1  asynchronous, active-low reset
- `axiiv`  in  1  dibit valid from the preamble stripper; high for the whole payload, then low
- `axiid`  in  2  payload dibit, LSB dibit of each byte first
- `axiov`  out  1  one-cycle pulse: `axiod` holds a byte
- `axiod`  out  8  assembled byte
- `axiol`  out  1  qualifies `axiov`; high on the final byte of a frame
- `frame_done`  out  1  one-cycle pulse at end of frame
- `frame_ok`  out  1  frame verdict; valid on `frame_done` and held until the next `frame_done`
- `byte_count`  out  11  completed bytes in the frame, saturating at 2047; valid on `frame_done` and held

## Operation
- States:
  - IDLE: entered from reset. Moves to RECV on the first edge with `axiiv`=1; that dibit is captured as dibit 0.
  - RECV: while `axiiv`=1, one dibit is consumed per edge.
- Dibit counter (2 bits): shift register packs `byte = {d3,d2,d1,d0}`.
- On the 4th dibit:
  - If `hold_valid`=1, the held byte is emitted with `axiol`=0.
  - The new byte is loaded into hold, `hold_valid`=1, and `byte_count` increments (saturating).
- First edge in RECV with `axiiv`=0 (end of frame):
  - If `hold_valid`, the held byte is emitted with `axiol`=1.
  - `frame_done`=1 and `frame_ok` is updated.
  - Then: return to IDLE and clear the dibit counter, `hold_valid` and the CRC.
- Misalignment: a nonzero dibit counter at end of frame is a misaligned frame. The partial byte is discarded and `frame_ok`=0.
- Zero-byte frame (fewer than 4 dibits): `frame_done` pulses, no byte is emitted, `frame_ok`=0.
- CRC-32:
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Updated 2 bits per consumed dibit, bit 0 first.
  - Good frame: register equals the residue 0xDEBB20E3 after the FCS.
- `frame_ok` = (CRC residue match) AND aligned AND `byte_count` ≥ `MIN_BYTES`.
- `axiov` and `frame_done` are single-cycle pulses. They coincide only at end of frame.

## Timing
- All outputs are registered.
- Reset values: `axiov`=0, `axiod`=0, `axiol`=0, `frame_done`=0, `frame_ok`=0, `byte_count`=0. State=IDLE, hold empty, CRC=0xFFFFFFFF.
- Byte N is emitted in the cycle after the edge that samples dibit 3 of byte N+1.
- The last byte and `frame_done` appear in the cycle after the first edge sampling `axiiv`=0.
- Minimum spacing between `axiov` pulses is 4 cycles, except the final byte, which may follow its predecessor by 1–4 cycles.
- `axiiv` may reassert the cycle after it drops. The end-of-frame edge is processed first, and the next edge starts a new frame with no lost dibit.
- Reset asserted mid-frame: everything clears immediately, with no `frame_done` and no emission of the held byte.
- `byte_count` saturation: stays at 2047; emission continues unaffected.

## Configuration
- `RMII_FCS_CHECK_EN` defined: CRC-32 logic is present and gates `frame_ok` as above.
- `RMII_FCS_CHECK_EN` undefined:
  - No CRC logic.
  - `frame_ok` = aligned AND `byte_count` ≥ `MIN_BYTES`.
  - Byte stream and timing are identical.

## Test plan
- Reset, then dibits 01,10,11,00 followed by `axiiv`=0:
  - Byte 0x39 is emitted with `axiol`=1 alongside `frame_done`.
  - `byte_count`=1, `frame_ok`=0.
- FCS pass: ASCII "123456789" plus FCS bytes 0x26,0x39,0xF4,0xCB, sent as 52 dibits:
  - 13 bytes in order, only the last with `axiol`=1.
  - `byte_count`=13, `frame_ok`=1.
  - With the macro undefined, `frame_ok`=1 as well.
- FCS fail: same frame with the last byte 0xCA:
  - `frame_ok`=0 with the macro defined, 1 with it undefined.
- Misaligned: the 52-dibit frame above plus 2 extra dibits:
  - 13 bytes emitted, `frame_ok`=0, `byte_count`=13.
- Back-to-back: `axiiv` low for exactly 1 cycle between two copies of the good frame:
  - Two `frame_done` pulses, 26 bytes total, both `frame_ok`=1.
- Reset mid-frame: `rst_n` pulsed low after 6 bytes, then the good frame is sent:
  - No `frame_done` for the aborted frame.
  - The next frame yields `byte_count`=13, `frame_ok`=1.
